// File: rtl/fast_nms_3x3_if.sv
//============================================================================
// Module  : fast_nms_3x3_if
// Brief   : Pixel-in / keypoint-out bundle for the 3x3 NMS stage.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface fast_nms_3x3_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           i_valid;
  logic           i_sof;
  logic           i_flag;
  logic [7:0]     i_score;
  logic           o_valid;
  logic           o_keypoint;
  logic [7:0]     o_score;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;

  modport master (
    output i_valid, i_sof, i_flag, i_score,
    input  o_valid, o_keypoint, o_score, o_x, o_y
  );

  modport slave (
    input  i_valid, i_sof, i_flag, i_score,
    output o_valid, o_keypoint, o_score, o_x, o_y
  );
endinterface

`default_nettype wire

// File: rtl/fast_nms_3x3.sv
//============================================================================
// Module  : fast_nms_3x3
// Brief   : Streaming 3x3 non-maximum suppression of FAST-9 corner scores.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module fast_nms_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  fast_nms_3x3_if.slave     nms
);

  localparam logic [X_W-1:0] c_x_one  = X_W'(1);
  localparam logic [X_W-1:0] c_x_two  = X_W'(2);
  localparam logic [X_W-1:0] c_x_last = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0] c_x_cmax = X_W'(IMG_W - 2);
  localparam logic [Y_W-1:0] c_y_one  = Y_W'(1);
  localparam logic [Y_W-1:0] c_y_two  = Y_W'(2);
  localparam logic [Y_W-1:0] c_y_last = Y_W'(IMG_H - 1);
  localparam logic [Y_W-1:0] c_y_cmax = Y_W'(IMG_H - 2);

  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic                  r_sel;
  logic [7:0]            r_lb0 [IMG_W];
  logic [7:0]            r_lb1 [IMG_W];
  logic [2:0][2:0][7:0]  r_win;

  logic                  r_v1;
  logic                  r_cand1;
  logic [X_W-1:0]        r_cx1;
  logic [Y_W-1:0]        r_cy1;

  logic                  r_ov;
  logic                  r_okp;
  logic [7:0]            r_osc;
  logic [X_W-1:0]        r_ox;
  logic [Y_W-1:0]        r_oy;

  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;
  logic [7:0]            w_m;
  logic [7:0]            w_up1;
  logic [7:0]            w_up2;
  logic                  w_x_end;
  logic [X_W-1:0]        w_cx;
  logic [Y_W-1:0]        w_cy;
  logic                  w_cand;
  logic [7:0]            w_c;
  logic                  w_keep;

  // Start-of-frame overrides the running counters for the current pixel.
  assign w_x     = nms.i_sof ? '0 : r_x;
  assign w_y     = nms.i_sof ? '0 : r_y;
  assign w_m     = nms.i_flag ? nms.i_score : 8'd0;
  assign w_x_end = (w_x == c_x_last);

  // r_sel=0: lb0 holds row y-1 and lb1 row y-2; roles swap at each line end.
  assign w_up1 = r_sel ? r_lb1[w_x] : r_lb0[w_x];
  assign w_up2 = r_sel ? r_lb0[w_x] : r_lb1[w_x];

  assign w_cx   = (w_x != '0) ? (w_x - c_x_one) : '0;
  assign w_cy   = (w_y != '0) ? (w_y - c_y_one) : '0;
  assign w_cand = (w_x >= c_x_two) && (w_y >= c_y_two) &&
                  (w_cx <= c_x_cmax) && (w_cy <= c_y_cmax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sel <= 1'b0;
    end else if (nms.i_valid) begin
      if (w_x_end) begin
        r_x   <= '0;
        r_y   <= (w_y == c_y_last) ? '0 : (w_y + c_y_one);
        r_sel <= ~r_sel;
      end else begin
        r_x   <= w_x + c_x_one;
        r_y   <= w_y;
      end
    end
  end

  // The row y-2 buffer is read before being overwritten with row y.
  always_ff @(posedge i_clk) begin
    if (nms.i_valid) begin
      if (r_sel) begin
        r_lb0[w_x] <= w_m;
      end else begin
        r_lb1[w_x] <= w_m;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win   <= '0;
      r_v1    <= 1'b0;
      r_cand1 <= 1'b0;
      r_cx1   <= '0;
      r_cy1   <= '0;
    end else begin
      r_v1 <= nms.i_valid;
      if (nms.i_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_up2;
        r_win[1][2] <= w_up1;
        r_win[2][2] <= w_m;
        r_cand1     <= w_cand;
        r_cx1       <= w_cx;
        r_cy1       <= w_cy;
      end
    end
  end

  // Strict against raster-earlier neighbours, non-strict against later ones.
  assign w_c    = r_win[1][1];
  assign w_keep = r_cand1 && (w_c != 8'd0) &&
                  (w_c >  r_win[0][0]) && (w_c >  r_win[0][1]) &&
                  (w_c >  r_win[0][2]) && (w_c >  r_win[1][0]) &&
                  (w_c >= r_win[1][2]) && (w_c >= r_win[2][0]) &&
                  (w_c >= r_win[2][1]) && (w_c >= r_win[2][2]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ov  <= 1'b0;
      r_okp <= 1'b0;
      r_osc <= 8'd0;
      r_ox  <= '0;
      r_oy  <= '0;
    end else begin
      r_ov <= r_v1;
      if (r_v1) begin
        r_okp <= w_keep;
        r_osc <= w_keep ? w_c : 8'd0;
        r_ox  <= r_cx1;
        r_oy  <= r_cy1;
      end
    end
  end

  assign nms.o_valid    = r_ov;
  assign nms.o_keypoint = r_okp;
  assign nms.o_score    = r_osc;
  assign nms.o_x        = r_ox;
  assign nms.o_y        = r_oy;

endmodule

`default_nettype wire
